// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / taken-branch detection, E-stage forwarding, mul/div stall sequencing.
// Latency: all outputs combinational from inputs and FSM state; the mul/div FSM advances one step per clk.
// Backpressure: a mul/div op holds F/D/E for MD_LATENCY-1 cycles and bubbles M; load-use holds F/D for 1 cycle.
module hazard_ctrl #(
  parameter int MD_LATENCY = 3,
  parameter int RegAddrW   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RegAddrW-1:0] Rs1D,
  input  logic [RegAddrW-1:0] Rs2D,
  input  logic [RegAddrW-1:0] Rs1E,
  input  logic [RegAddrW-1:0] Rs2E,
  input  logic [RegAddrW-1:0] RdE,
  input  logic [RegAddrW-1:0] RdM,
  input  logic [RegAddrW-1:0] RdW,
  input  logic                ResultSrcE0,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic                PCSrcE,
  input  logic                MdStartE,
  output logic                StallF,
  output logic                StallD,
  output logic                StallE,
  output logic                FlushD,
  output logic                FlushE,
  output logic                FlushM,
  output logic                MdDoneE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE
);

  localparam int CntW = $clog2(MD_LATENCY);
  localparam logic [CntW-1:0] CntInit = CntW'(MD_LATENCY - 2);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            md_stall;
  logic            md_done;
  logic            lw_stall;
  logic            d_uses_rde;

  // Mul/div state register; reset forces IDLE regardless of where the op was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mul/div sequencing: stall starts the same cycle the op appears in E, DONE is the result cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MdStartE) begin
          md_stall = 1'b1;
          cnt_d    = CntInit;
          state_d  = (MD_LATENCY == 2) ? DONE : BUSY;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        cnt_d    = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // MdStartE is still high for the finishing op; do not retrigger on it.
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall/flush decode; everything drops combinationally while reset is high.
  always_comb begin
    d_uses_rde = (Rs1D == RdE) || (Rs2D == RdE);
    // A taken branch squashes D anyway, and a mul/div in E means no load sits there.
    lw_stall   = ResultSrcE0 && (RdE != '0) && d_uses_rde && !PCSrcE && !md_stall;
    StallF     = !reset && (lw_stall || md_stall);
    StallD     = !reset && (lw_stall || md_stall);
    StallE     = !reset && md_stall;
    FlushD     = !reset && PCSrcE && !md_stall;
    FlushE     = !reset && (lw_stall || PCSrcE) && !md_stall;
    FlushM     = !reset && md_stall;
    MdDoneE    = !reset && md_done;
  end

  // Forwarding select: the younger M result wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MD_LATENCY 2/3/5) share one stimulus stream.
// Each cycle every output is compared against a cycle-count reference model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_hazard_ctrl;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 3, 5};

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MdStartE;
  // [10]StallF [9]StallD [8]StallE [7]FlushD [6]FlushE [5]FlushM [4]MdDoneE [3:2]FwdA [1:0]FwdB
  logic [10:0] o [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int age [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_ctrl #(.MD_LATENCY(LAT[g]), .RegAddrW(5)) u_dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MdStartE(MdStartE),
      .StallF(o[g][10]), .StallD(o[g][9]), .StallE(o[g][8]),
      .FlushD(o[g][7]), .FlushE(o[g][6]), .FlushM(o[g][5]), .MdDoneE(o[g][4]),
      .ForwardAE(o[g][3:2]), .ForwardBE(o[g][1:0])
    );
  end

  // The same E instruction cannot be both mul/div and a load or branch.
  always @(negedge clk) begin
    assert (!(MdStartE && (ResultSrcE0 || PCSrcE)));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Cycle number of the current mul/div op (1..L), 0 when none is in flight.
  function automatic int cur_of(int g);
    if (reset) return 0;
    if (age[g] == 0) return MdStartE ? 1 : 0;
    return age[g];
  endfunction

  function automatic logic [1:0] fwd(logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model(int g);
    int   c;
    logic st, dn, lw;
    c  = cur_of(g);
    st = (c >= 1) && (c <= LAT[g] - 1);
    dn = (c == LAT[g]);
    lw = !reset && ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE) && !PCSrcE && !st;
    return {lw || st, lw || st, st,
            !reset && PCSrcE && !st,
            !reset && (lw || PCSrcE) && !st,
            st, dn, fwd(Rs1E), fwd(Rs2E)};
  endfunction

  // Compare all instances at the falling edge, away from the state update.
  task automatic sample();
    logic [10:0] e;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      e = model(g);
      chk($sformatf("L%0d_ctl", LAT[g]), 32'(o[g][10:4]), 32'(e[10:4]));
      chk($sformatf("L%0d_fwdA", LAT[g]), 32'(o[g][3:2]), 32'(e[3:2]));
      chk($sformatf("L%0d_fwdB", LAT[g]), 32'(o[g][1:0]), 32'(e[1:0]));
    end
  endtask

  task automatic advance();
    int c;
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      c = cur_of(g);
      age[g] = (c == 0 || c == LAT[g]) ? 0 : c + 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MdStartE} = '0;
  endtask

  int  stalls [NI];
  int  done_at [NI];
  logic md_prev;

  initial begin
    for (int g = 0; g < NI; g++) age[g] = 0;
    clear_inputs();
    reset = 1'b1;
    MdStartE = 1'b1;
    // Reset state: no stalls even with MdStartE high.
    sample();
    chk("rst_stallF", 32'(o[1][10]), 0);
    chk("rst_flushM", 32'(o[1][5]), 0);
    advance();
    MdStartE = 1'b0;
    reset = 1'b0;
    sample();
    advance();

    // Load-use hazard and the x0 exception.
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    sample();
    chk("lu_stallF", 32'(o[1][10]), 1);
    chk("lu_flushE", 32'(o[1][6]), 1);
    chk("lu_stallE", 32'(o[1][8]), 0);
    advance();
    RdE = 5'd0; Rs1D = 5'd0;
    sample();
    chk("lu_x0", 32'(o[1][10]), 0);
    advance();

    // Taken branch overrides a concurrent load-use match.
    RdE = 5'd9; Rs2D = 5'd9; PCSrcE = 1'b1;
    sample();
    chk("br_flushD", 32'(o[1][7]), 1);
    chk("br_flushE", 32'(o[1][6]), 1);
    chk("br_stallF", 32'(o[1][10]), 0);
    advance();
    clear_inputs();

    // Forwarding priority and x0.
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7;
    sample();
    chk("fw_M", 32'(o[1][3:2]), 32'h2);
    advance();
    RegWriteM = 1'b0;
    sample();
    chk("fw_W", 32'(o[1][3:2]), 32'h1);
    advance();
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs2E = 5'd0;
    sample();
    chk("fw_x0", 32'(o[1][1:0]), 32'h0);
    advance();
    clear_inputs();

    // Held mul/div op: count stall cycles and the done cycle per latency; back-to-back restart.
    for (int g = 0; g < NI; g++) begin stalls[g] = 0; done_at[g] = 0; end
    MdStartE = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      sample();
      for (int g = 0; g < NI; g++) begin
        if (done_at[g] == 0 && o[g][8]) stalls[g]++;
        if (done_at[g] == 0 && o[g][4]) done_at[g] = cyc;
      end
      if (cyc == 4) chk("md3_restart", 32'(o[1][8]), 1);
      advance();
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("L%0d_nstall", LAT[g]), 32'(stalls[g]), 32'(LAT[g] - 1));
      chk($sformatf("L%0d_doneat", LAT[g]), 32'(done_at[g]), 32'(LAT[g]));
    end
    MdStartE = 1'b0;
    repeat (6) begin sample(); advance(); end

    // Reset while the L=3 instance is BUSY.
    MdStartE = 1'b1;
    sample();
    advance();
    reset = 1'b1;
    sample();
    chk("rb_stallE", 32'(o[1][8]), 0);
    chk("rb_flushM", 32'(o[1][5]), 0);
    chk("rb_done", 32'(o[1][4]), 0);
    advance();
    reset = 1'b0; MdStartE = 1'b0;
    repeat (3) begin
      sample();
      chk("rb_idle", 32'(o[1][10:4]), 0);
      advance();
    end

    // Randomized traffic.
    md_prev = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      MdStartE = md_prev ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
      md_prev = MdStartE;
      ResultSrcE0 = !MdStartE && ($urandom_range(0, 2) == 0);
      PCSrcE      = !MdStartE && ($urandom_range(0, 4) == 0);
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
